// File: rtl/hc86_out_deser.sv
// Deserializer for the hc86 XOR gate output: packs accepted bits LSB-first into
// parity-tagged, counted words on a valid/ready port. Optional checker: HC86_CHECK_EN.
module hc86_out_deser #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             flush,
  input  logic             chk_a,
  input  logic             chk_b,
  output logic [WIDTH-1:0] word_out,
  output logic             word_par,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic [7:0]       err_cnt,
  output logic             err_flag
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] idx;
  logic [WIDTH-2:0] asm_q;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] full_word;

  // The final bit stalls only while a completed word is still waiting downstream.
  assign last      = (idx == LAST_IDX);
  assign bit_ready = !(word_valid && last);
  assign accept    = bit_valid && bit_ready && !flush;
  assign full_word = {bit_in, asm_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      asm_q      <= '0;
      word_out   <= '0;
      word_par   <= 1'b0;
      word_valid <= 1'b0;
      word_cnt   <= '0;
    end else begin
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (flush) begin
        idx   <= '0;
        asm_q <= '0;
      end else if (accept) begin
        if (!last) begin
          asm_q <= asm_q | ((WIDTH-1)'(bit_in) << idx);
          idx   <= idx + IDX_W'(1);
        end else begin
          // Output register is free here: bit_ready forbids this branch while holding.
          word_out   <= full_word;
          word_par   <= ^full_word;
          word_valid <= 1'b1;
          word_cnt   <= word_cnt + CNT_W'(1);
          idx        <= '0;
          asm_q      <= '0;
        end
      end
    end
  end

`ifdef HC86_CHECK_EN
  logic mismatch;

  assign mismatch = bit_in != (chk_a ^ chk_b);

  // Saturating mismatch counter plus sticky flag, updated on every kept bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (accept && mismatch) begin
      if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
      err_flag <= 1'b1;
    end
  end
`else
  logic unused_chk;

  assign unused_chk = chk_a ^ chk_b;
  assign err_cnt    = '0;
  assign err_flag   = 1'b0;
`endif

endmodule

// File: doc/hc86_out_deser.md
Name: hc86_out_deser

Overview:
- Downstream consumer of the hc86 quad-XOR gate output.
- Samples the gate's serial output one bit per accepted cycle and packs bits LSB-first into WIDTH-bit words.
- Attaches even parity and a running word count, then presents each word on a valid/ready interface to the board-level logger/UART stage.
- An optional checker recomputes a^b from the gate's own inputs and counts mismatches.

Parameters:
- WIDTH, 8, bits per output word (legal 2..32).
- CNT_W, 16, width of emitted-word counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  hc86 gate output (pout) being collected.
- bit_valid  input  1  bit_in is meaningful this cycle.
- bit_ready  output  1  block accepts bit_in this cycle.
- flush  input  1  discard partial word.
- chk_a  input  1  gate input a, aligned with bit_in (used only with checker).
- chk_b  input  1  gate input b, aligned with bit_in (used only with checker).
- word_out  output  WIDTH  assembled word, first bit in bit 0.
- word_par  output  1  XOR of all word_out bits.
- word_valid  output  1  word_out/word_par/word_cnt valid.
- word_ready  input  1  consumer takes word.
- word_cnt  output  CNT_W  number of words emitted, including the current one.
- err_cnt  output  8  checker mismatch count.
- err_flag  output  1  sticky checker mismatch.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-word): assembly register 0, bit index 0, word_out 0, word_par 0, word_valid 0, word_cnt 0, err_cnt 0, err_flag 0. Partial word and any held word are lost.
- Accept condition: bit_valid && bit_ready at a rising edge.
- bit_ready = !(word_valid && idx == WIDTH-1). It is a function of registered state only; there is no combinational path from word_ready.
- On accept with idx < WIDTH-1:
  - asm[idx] <= bit_in.
  - idx <= idx+1.
- On accept with idx == WIDTH-1 (output register is guaranteed free):
  - word_out <= {bit_in, asm[WIDTH-2:0]}.
  - word_par <= XOR of that value.
  - word_valid <= 1.
  - word_cnt <= word_cnt+1, wrapping at 2^CNT_W to 0.
  - idx <= 0.
  - asm <= 0.
- Latency: word_valid rises the cycle after the WIDTH-th bit is accepted.
- Output handshake: word_valid falls the cycle after word_valid && word_ready. word_out, word_par and word_cnt are held stable while word_valid=1 && !word_ready.
- Same-edge handoff: the last bit can load a new word on the same edge the old word is consumed, but only if bit_ready was already 1. Since bit_ready=0 while word_valid=1 and idx==WIDTH-1, a stalled full word back-pressures exactly one bit position.
- Flush:
  - flush=1: idx <= 0 and asm <= 0; any bit_valid that cycle is dropped and not counted.
  - word_valid and the held word are unaffected.
  - flush takes priority over the accept rule.
- Idle (bit_valid=0): no state change except the output handshake.
- States are implicit: FILL (word_valid=0), HOLD (word_valid=1). Transitions are as above.

Optional Feature:
- HC86_CHECK_EN defined:
  - On each accepted bit (not flushed), mismatch = bit_in != (chk_a ^ chk_b).
  - On mismatch: err_cnt increments and saturates at 255; err_flag <= 1 and is sticky until rst.
  - Check result is visible the cycle after the accept.
- HC86_CHECK_EN undefined:
  - chk_a and chk_b are ignored.
  - err_cnt is tied to 0 and err_flag is tied to 0.
  - Port list is unchanged.

Test Plan (WIDTH=8):
- Reset then feed bits 1,0,1,1,0,0,1,0 on consecutive cycles with word_ready=1 -> next cycle word_out=8'h4D, word_par=0, word_valid=1, word_cnt=1; word_valid drops one cycle later.
- Hold word_ready=0 and stream 16 bits (8'hFF then 8'h01) -> first word 8'hFF/par 0 holds; bit_ready=0 at the 16th bit until word_ready=1; then 8'h01, par 1, word_cnt=2.
- Feed 3 bits, assert flush while bit_valid=1, then feed 8 bits of 8'hA5 -> emitted word is exactly 8'hA5, word_cnt=1.
- Assert rst mid-word (5 bits in) and during word_valid=1 -> all outputs 0 immediately; the next 8 bits form a fresh word.
- Sweep 256 words with word_ready=1 and CNT_W=8 -> word_cnt wraps 255->0.
- HC86_CHECK_EN: drive chk_a/chk_b through 00,01,11,10 with bit_in=a^b except one forced error -> err_cnt=1, err_flag=1. With 300 forced errors -> err_cnt=255. Without the macro, both outputs stay 0.
